pixel_stream_engine: RTL and testbench
======================================

Name: pixel_stream_engine

Overview:
Parametrised multi-cycle pixel processor. It reads a block of pixels from the raw-image memory, applies a per-pixel operation selected by mode, and writes the results to the processed-image memory. It generalises the fixed 8-bit raw/processed image address stepping into a start/done-controlled engine with configurable pixel width, address width, memory latency and operation modes. It sits between the raw and processed image memories, beside the processor core, which launches it and polls it.

Parameters:
PIX_W, 8, pixel width in bits.
ADDR_W, 18, image memory address width.
RD_LAT, 1, source memory read latency in cycles; legal range 1..3.

Ports:
clk  in  1  system clock.
rst  in  1  reset.
start  in  1  launch request; sampled only in IDLE.
mode  in  3  operation select; latched at start.
src_base  in  ADDR_W  first source address; latched at start.
dst_base  in  ADDR_W  first destination address; latched at start.
pix_count  in  ADDR_W  number of source pixels; latched at start.
param  in  PIX_W  threshold or addend; latched at start.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle completion pulse.
src_rd_en  out  1  source read strobe.
src_addr  out  ADDR_W  source read address.
src_rd_data  in  PIX_W  source read data, valid RD_LAT cycles after src_rd_en.
dst_we  out  1  destination write strobe.
dst_addr  out  ADDR_W  destination write address.
dst_wd  out  PIX_W  destination write data.
progress  out  ADDR_W  count of source pixels fully processed.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- While rst=0 at a rising edge:
  - FSM goes to IDLE.
  - busy, done, src_rd_en, dst_we are 0.
  - src_addr, dst_addr, dst_wd, progress are 0.
  - Latched configuration is cleared.
  - Asserting reset mid-run aborts the run: no further reads or writes occur and no done pulse is issued.
- FSM states: IDLE, RD, WAIT, WR, DONE (plus WR2 with the optional feature).
- IDLE:
  - start=1 latches the configuration and clears the pixel index i and progress.
  - If pix_count=0, go to DONE; otherwise go to RD.
- RD (1 cycle): src_rd_en=1, src_addr=src_base+i (mod 2^ADDR_W).
- WAIT (RD_LAT cycles): at the final WAIT edge, src_rd_data is captured into pix_reg and the result is computed into res_reg.
- WR (1 cycle): dst_we=1, dst_addr=dst_base+i (mod 2^ADDR_W), dst_wd=res_reg.
  - progress increments at the end of WR.
  - If i=pix_count-1, go to DONE; otherwise i++ and go to RD.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Throughput: RD_LAT+2 cycles per pixel. Writes occur in ascending address order.
- Modes (MAX = 2^PIX_W-1):
  - 0: copy, res = p.
  - 1: invert, res = MAX-p.
  - 2: threshold, res = (p>=param) ? MAX : 0.
  - 3: saturating add, res = min(p+param, MAX), computed in PIX_W+1 bits.
  - 4: interpolate (optional feature only).
  - 5..7: treated as copy.
- start while busy is ignored; configuration inputs may change freely during a run.
- Address arithmetic wraps silently at 2^ADDR_W.
- All outputs are registered or derived only from state plus registers; no combinational path from inputs to outputs.

Optional Feature:
PSE_INTERP_EN.
- Defined: mode 4 performs 2x horizontal linear interpolation and writes 2*pix_count destination pixels.
  - For each source pixel i, write dst_base+2i = p[i] and dst_base+2i+1 = floor((p[i]+p[i+1])/2), with the sum computed in PIX_W+1 bits.
  - For the last pixel, p[i+1] is replaced by p[i].
  - Implementation: the previous pixel is held in a register. Each pair of writes takes states WR then WR2, issued after p[i+1] has been read. The last pair needs no extra read.
  - progress counts source pixels.
  - Each source pixel is read exactly once.
- Not defined: mode 4 behaves as copy; WR2 and the extra pixel register are absent.

Test Plan:
1. Reset: hold rst=0 for 2 cycles during an active copy run -> next cycle busy=0, done=0, src_rd_en=0, dst_we=0, progress=0; no later writes occur.
2. Copy, RD_LAT=1, src_base=0x10, dst_base=0x100, pix_count=4, memory {10,20,30,40}:
   - dst 0x100..0x103 = {10,20,30,40}.
   - Exactly 4 reads and 4 writes.
   - done is high exactly 13 cycles after the start edge; progress=4.
3. Modes, per-pixel input -> output:
   - Invert: 0x00 -> 0xFF, 0x5A -> 0xA5.
   - Threshold, param=128: {127,128,255,0} -> {0,255,255,0}.
   - Saturating add, param=200: {50,60} -> {250,255}.
4. Edge cases:
   - pix_count=0 -> done one cycle after start, with no src_rd_en and no dst_we.
   - start pulsed mid-run -> ignored; original run completes unchanged.
   - dst_base=0x3FFFF, pix_count=2 -> writes go to 0x3FFFF then 0x00000.
5. RD_LAT=3, copy, pix_count=2 -> 5 cycles per pixel; captured data matches memory contents.
6. Interpolate, mode 4, data {10,20,31}:
   - With PSE_INTERP_EN: dst {10,15,20,25,31,31}, 3 reads, 6 writes.
   - Without PSE_INTERP_EN: dst {10,20,31}.

Source files
------------

// File: rtl/pixel_stream_engine.sv
// pixel_stream_engine: start/done block processor that reads raw pixels, applies a mode-selected
// operation and writes processed pixels. Define PSE_INTERP_EN for mode-4 2x horizontal interpolation.
module pixel_stream_engine #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 18,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] pix_count,
    input  logic [PIX_W-1:0]  param,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_rd_data,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_wd,
    output logic [ADDR_W-1:0] progress
);

    localparam logic [PIX_W-1:0] MAX_PIX  = '1;
    localparam logic [1:0]       WAIT_END = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_WR, S_DONE
`ifdef PSE_INTERP_EN
        , S_WR2
`endif
    } state_t;

    state_t            state, state_n;
    logic [2:0]        mode_r;
    logic [ADDR_W-1:0] src_base_r, dst_base_r, count_r, idx;
    logic [PIX_W-1:0]  param_r, res_reg, res_next;
    logic [1:0]        wait_cnt;
    logic [PIX_W:0]    sum;
    logic              wait_last, last_src;

`ifdef PSE_INTERP_EN
    logic [PIX_W-1:0]  pix_reg, prev_reg, avg;
    logic [ADDR_W-1:0] pair_idx;
    logic              last_pair, interp;

    assign interp = (mode_r == 3'd4);
    // floor((a+b)/2) without a carry bit: halves plus the carry of the two LSBs.
    assign avg = (prev_reg >> 1) + (pix_reg >> 1) + PIX_W'(prev_reg[0] & pix_reg[0]);
`endif

    assign wait_last = (wait_cnt == WAIT_END);
    assign last_src  = (idx == count_r - 1'b1);

    always_comb begin
        sum = {1'b0, src_rd_data} + {1'b0, param_r};
        case (mode_r)
            3'd1:    res_next = MAX_PIX - src_rd_data;
            3'd2:    res_next = (src_rd_data >= param_r) ? MAX_PIX : '0;
            3'd3:    res_next = sum[PIX_W] ? MAX_PIX : sum[PIX_W-1:0];
            default: res_next = src_rd_data;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // NOTE: next state gets its default first, so no path through this block can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = (pix_count == '0) ? S_DONE : S_RD;
            S_RD:   state_n = S_WAIT;
            S_WAIT: if (wait_last) begin
                state_n = S_WR;
`ifdef PSE_INTERP_EN
                // The first interpolated pixel waits for its right neighbour to be read.
                if (interp && idx == '0 && !last_src) state_n = S_RD;
`endif
            end
            S_WR: begin
                state_n = last_src ? S_DONE : S_RD;
`ifdef PSE_INTERP_EN
                if (interp) state_n = S_WR2;
`endif
            end
`ifdef PSE_INTERP_EN
            S_WR2:   state_n = last_pair ? S_DONE : (last_src ? S_WR : S_RD);
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        src_rd_en = (state == S_RD);
        src_addr  = (state == S_RD) ? src_base_r + idx : '0;
        dst_we    = (state == S_WR);
        dst_addr  = (state == S_WR) ? dst_base_r + idx : '0;
        dst_wd    = (state == S_WR) ? res_reg : '0;
`ifdef PSE_INTERP_EN
        if (interp && state == S_WR) begin
            dst_addr = dst_base_r + (pair_idx << 1);
            dst_wd   = prev_reg;
        end
        if (state == S_WR2) begin
            dst_we   = 1'b1;
            dst_addr = dst_base_r + (pair_idx << 1) + ADDR_W'(1);
            dst_wd   = avg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_r     <= '0;
            src_base_r <= '0;
            dst_base_r <= '0;
            count_r    <= '0;
            param_r    <= '0;
            idx        <= '0;
            progress   <= '0;
            wait_cnt   <= '0;
            res_reg    <= '0;
`ifdef PSE_INTERP_EN
            pix_reg    <= '0;
            prev_reg   <= '0;
            pair_idx   <= '0;
            last_pair  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_r     <= mode;
                    src_base_r <= src_base;
                    dst_base_r <= dst_base;
                    count_r    <= pix_count;
                    param_r    <= param;
                    idx        <= '0;
                    progress   <= '0;
`ifdef PSE_INTERP_EN
                    pair_idx   <= '0;
                    last_pair  <= 1'b0;
`endif
                end
                S_RD: wait_cnt <= '0;
                S_WAIT: if (wait_last) begin
                    res_reg <= res_next;
`ifdef PSE_INTERP_EN
                    pix_reg <= src_rd_data;
                    if (interp && idx == '0) begin
                        prev_reg <= src_rd_data;
                        if (last_src) last_pair <= 1'b1;
                        else          idx       <= idx + 1'b1;
                    end
`endif
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_WR: begin
`ifdef PSE_INTERP_EN
                    if (!interp) begin
                        progress <= progress + 1'b1;
                        if (!last_src) idx <= idx + 1'b1;
                    end
`else
                    progress <= progress + 1'b1;
                    if (!last_src) idx <= idx + 1'b1;
`endif
                end
`ifdef PSE_INTERP_EN
                S_WR2: begin
                    progress <= progress + 1'b1;
                    pair_idx <= pair_idx + 1'b1;
                    if (!last_pair) begin
                        prev_reg <= pix_reg;
                        if (last_src) last_pair <= 1'b1;
                        else          idx       <= idx + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_engine.sv
// tb_pixel_stream_engine: vector table, hand-written corner sequences and randomized runs
// compared with a behavioural model; one instance with RD_LAT=1 and one with RD_LAT=3.
module tb_pixel_stream_engine;
    localparam int PW = 8;
    localparam int AW = 18;
`ifdef PSE_INTERP_EN
    localparam bit INTERP = 1'b1;
`else
    localparam bit INTERP = 1'b0;
`endif
    localparam logic [PW-1:0] NO_DATA = 8'hC3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    typedef struct {
        logic [2:0]    mode;
        logic [PW-1:0] param;
        logic [PW-1:0] pin;
        logic [PW-1:0] pout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [2:0]    mode = '0;
    logic [AW-1:0] src_base = '0, dst_base = '0, pix_count = '0;
    logic [PW-1:0] param = '0;

    logic          busy_a, done_a, rd_en_a, we_a, busy_b, done_b, rd_en_b, we_b;
    logic [AW-1:0] saddr_a, daddr_a, prog_a, saddr_b, daddr_b, prog_b;
    logic [PW-1:0] rdata_a, wd_a, rdata_b, wd_b;
    logic [PW-1:0] pipe_b [3];
    logic [PW-1:0] mem [1024];

    wr_t wq_a[$], wq_b[$], exp_q[$];
    int  rd_a = 0, rd_b = 0;
    int  total = 0, bad = 0;

    always #5 clk = ~clk;

    pixel_stream_engine #(.PIX_W(PW), .ADDR_W(AW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .src_base(src_base),
        .dst_base(dst_base), .pix_count(pix_count), .param(param), .busy(busy_a),
        .done(done_a), .src_rd_en(rd_en_a), .src_addr(saddr_a), .src_rd_data(rdata_a),
        .dst_we(we_a), .dst_addr(daddr_a), .dst_wd(wd_a), .progress(prog_a)
    );

    pixel_stream_engine #(.PIX_W(PW), .ADDR_W(AW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .src_base(src_base),
        .dst_base(dst_base), .pix_count(pix_count), .param(param), .busy(busy_b),
        .done(done_b), .src_rd_en(rd_en_b), .src_addr(saddr_b), .src_rd_data(rdata_b),
        .dst_we(we_b), .dst_addr(daddr_b), .dst_wd(wd_b), .progress(prog_b)
    );

    // Source memories: data appears RD_LAT cycles after the strobe, a marker otherwise.
    always @(posedge clk) begin
        rdata_a   <= rd_en_a ? mem[saddr_a[9:0]] : NO_DATA;
        pipe_b[0] <= rd_en_b ? mem[saddr_b[9:0]] : NO_DATA;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_b = pipe_b[2];

    always @(negedge clk) begin
        if (we_a) wq_a.push_back('{daddr_a, wd_a});
        if (we_b) wq_b.push_back('{daddr_b, wd_b});
        if (rd_en_a) rd_a++;
        if (rd_en_b) rd_b++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix_op(input logic [2:0] m, input logic [PW-1:0] p,
                                             input logic [PW-1:0] pr);
        int maxv = (1 << PW) - 1;
        int r;
        case (m)
            3'd1:    r = maxv - int'(p);
            3'd2:    r = (p >= pr) ? maxv : 0;
            3'd3:    r = (int'(p) + int'(pr) > maxv) ? maxv : int'(p) + int'(pr);
            default: r = int'(p);
        endcase
        return PW'(r);
    endfunction

    function automatic logic [PW-1:0] src_pix(input logic [AW-1:0] base, input int i);
        logic [AW-1:0] a;
        a = AW'(int'(base) + i);
        return mem[a[9:0]];
    endfunction

    task automatic build_expected(input logic [2:0] m, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                                  input int n, input logic [PW-1:0] pr);
        logic [PW-1:0] p, nx;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            p = src_pix(sb, i);
            if (INTERP && m == 3'd4) begin
                nx = (i == n - 1) ? p : src_pix(sb, i + 1);
                exp_q.push_back('{AW'(int'(db) + 2 * i), p});
                exp_q.push_back('{AW'(int'(db) + 2 * i + 1), PW'((int'(p) + int'(nx)) / 2)});
            end else begin
                exp_q.push_back('{AW'(int'(db) + i), pix_op(m, p, pr)});
            end
        end
    endtask

    // Launch one run on instance a (b=0) or b (b=1), wait for done and compare everything.
    task automatic run(input bit b, input logic [2:0] m, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                       input int n, input logic [PW-1:0] pr, input int pulse_at, output int lat);
        wr_t q[$];
        int  reads;
        lat = 0;
        mode = m; src_base = sb; dst_base = db; pix_count = AW'(n); param = pr;
        wq_a.delete(); wq_b.delete(); rd_a = 0; rd_b = 0;
        build_expected(m, sb, db, n, pr);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        for (int j = 1; j <= 600 && lat == 0; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start_a = 1'b0; start_b = 1'b0;
                check("busy_after_start", b ? busy_b : busy_a, 1);
                mode = 3'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom);
                pix_count = AW'($urandom); param = PW'($urandom);
            end
            if (j == pulse_at) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end
            if (j == pulse_at + 1) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (b ? done_b : done_a) lat = j;
        end
        start_a = 1'b0; start_b = 1'b0;
        if (lat == 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("progress_at_done", b ? prog_b : prog_a, n);
            if (!(INTERP && m == 3'd4))
                check("done_latency", lat, (n == 0) ? 1 : n * ((b ? 3 : 1) + 2) + 1);
            @(negedge clk);
            check("done_one_cycle", b ? done_b : done_a, 0);
            check("idle_after_done", b ? busy_b : busy_a, 0);
        end
        if (b) begin q = wq_b; reads = rd_b; end
        else   begin q = wq_a; reads = rd_a; end
        check("write_count", q.size(), exp_q.size());
        check("read_count", reads, n);
        for (int k = 0; k < exp_q.size() && k < q.size(); k++) begin
            check("write_addr", q[k].addr, exp_q[k].addr);
            check("write_data", q[k].data, exp_q[k].data);
        end
    endtask

    initial begin
        vec_t vt[10];
        int   lat, dones;
        logic [PW-1:0] ip_exp [6];

        vt[0] = '{3'd1, 8'd0,   8'h00, 8'hFF};
        vt[1] = '{3'd1, 8'd0,   8'h5A, 8'hA5};
        vt[2] = '{3'd2, 8'd128, 8'd127, 8'd0};
        vt[3] = '{3'd2, 8'd128, 8'd128, 8'd255};
        vt[4] = '{3'd2, 8'd128, 8'd255, 8'd255};
        vt[5] = '{3'd2, 8'd128, 8'd0,   8'd0};
        vt[6] = '{3'd3, 8'd200, 8'd50,  8'd250};
        vt[7] = '{3'd3, 8'd200, 8'd60,  8'd255};
        vt[8] = '{3'd0, 8'd9,   8'h37,  8'h37};
        vt[9] = '{3'd6, 8'd9,   8'h81,  8'h81};

        for (int i = 0; i < 1024; i++) mem[i] = PW'($urandom);

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_progress_a", prog_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_we_b", we_b, 0);
        rst = 1'b1;
        @(negedge clk);

        // Copy of four pixels with RD_LAT=1.
        mem[10'h10] = 8'd10; mem[10'h11] = 8'd20; mem[10'h12] = 8'd30; mem[10'h13] = 8'd40;
        run(1'b0, 3'd0, 18'h10, 18'h100, 4, 8'd0, 0, lat);
        check("copy4_latency", lat, 13);
        for (int k = 0; k < 4 && k < wq_a.size(); k++) begin
            check("copy4_addr", wq_a[k].addr, 18'h100 + k);
            check("copy4_data", wq_a[k].data, 10 * (k + 1));
        end

        // Per-pixel mode vectors.
        for (int k = 0; k < 10; k++) begin
            mem[10'h20] = vt[k].pin;
            run(1'b0, vt[k].mode, 18'h20, 18'h200, 1, vt[k].param, 0, lat);
            if (wq_a.size() > 0) check("mode_vector", wq_a[0].data, vt[k].pout);
        end

        // Empty block: done right away, no memory traffic.
        run(1'b0, 3'd0, 18'h10, 18'h100, 0, 8'd0, 0, lat);
        check("empty_latency", lat, 1);

        // start during a run is ignored.
        run(1'b0, 3'd0, 18'h10, 18'h100, 4, 8'd0, 4, lat);
        check("midstart_latency", lat, 13);

        // Destination wrap at the top of the address space.
        run(1'b0, 3'd0, 18'h30, 18'h3FFFF, 2, 8'd0, 0, lat);
        if (wq_a.size() == 2) begin
            check("wrap_addr0", wq_a[0].addr, 18'h3FFFF);
            check("wrap_addr1", wq_a[1].addr, 18'h00000);
        end

        // Three-cycle read latency.
        run(1'b1, 3'd0, 18'h10, 18'h300, 2, 8'd0, 0, lat);
        check("lat3_latency", lat, 11);
        if (wq_b.size() == 2) begin
            check("lat3_data0", wq_b[0].data, 10);
            check("lat3_data1", wq_b[1].data, 20);
        end

        // Mode 4 on {10,20,31}.
        mem[10'h40] = 8'd10; mem[10'h41] = 8'd20; mem[10'h42] = 8'd31;
`ifdef PSE_INTERP_EN
        ip_exp = '{8'd10, 8'd15, 8'd20, 8'd25, 8'd31, 8'd31};
        run(1'b0, 3'd4, 18'h40, 18'h400, 3, 8'd0, 0, lat);
        check("interp_writes", wq_a.size(), 6);
        for (int k = 0; k < 6 && k < wq_a.size(); k++) check("interp_data", wq_a[k].data, ip_exp[k]);
`else
        ip_exp = '{8'd10, 8'd20, 8'd31, 8'd0, 8'd0, 8'd0};
        run(1'b0, 3'd4, 18'h40, 18'h400, 3, 8'd0, 0, lat);
        check("interp_writes", wq_a.size(), 3);
        for (int k = 0; k < 3 && k < wq_a.size(); k++) check("interp_data", wq_a[k].data, ip_exp[k]);
`endif
        run(1'b1, 3'd4, 18'h41, 18'h500, 1, 8'd0, 0, lat);

        // Randomized runs on both instances.
        for (int r = 0; r < 30; r++) begin
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), AW'($urandom), AW'($urandom),
                $urandom_range(0, 6), PW'($urandom), 0, lat);
        end

        // Reset in the middle of a run aborts it.
        mode = 3'd0; src_base = 18'h10; dst_base = 18'h100; pix_count = 18'd8;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_rd_en", rd_en_a, 0);
        check("abort_we", we_a, 0);
        check("abort_progress", prog_a, 0);
        check("abort_dst_addr", daddr_a, 0);
        rst = 1'b1;
        wq_a.delete(); rd_a = 0; dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("abort_no_writes", wq_a.size(), 0);
        check("abort_no_reads", rd_a, 0);
        check("abort_no_done", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
